// File: rtl/neuro_pkg.sv
// Shared definitions for the neuron datapath: decoder FSM states and the
// default data/window widths used by both the LIF neuron and the decoder.
package neuro_pkg;
  localparam int NEURO_DATA_W = 8;
  localparam int NEURO_WIN_W  = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    COUNT = 1'b1
  } dec_state_t;
endpackage

// File: rtl/spike_rate_decoder_if.sv
// Result channel of the spike-rate decoder: rate/sat payload, valid/ready
// handshake and the sticky overrun flag.
interface spike_rate_decoder_if
  import neuro_pkg::*;
#(
  parameter int CNT_W = NEURO_DATA_W
);
  logic [CNT_W-1:0] rate;
  logic             sat;
  logic             rate_valid;
  logic             rate_ready;
  logic             overrun;

  modport master (output rate, sat, rate_valid, overrun, input rate_ready);
  modport slave  (input rate, sat, rate_valid, overrun, output rate_ready);
endinterface

// File: rtl/spike_win_counter.sv
// Saturating spike counter plus window counter; flags the closing cycle and
// presents the final count (including the closing cycle's spike).
module spike_win_counter
  import neuro_pkg::*;
#(
  parameter int CNT_W = NEURO_DATA_W,
  parameter int WIN_W = NEURO_WIN_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_run,
  input  logic             i_spike,
  input  logic [WIN_W-1:0] i_win_len,
  output logic             win_done,
  output logic [CNT_W-1:0] win_count,
  output logic             win_sat
);
  logic [CNT_W-1:0] r_cnt;
  logic [WIN_W-1:0] r_wcnt;
  logic [WIN_W-1:0] r_win_len_q;
  logic             r_sat;
  logic             w_at_max;

  assign w_at_max  = &r_cnt;
  assign win_done  = i_run & (r_wcnt == r_win_len_q);
  assign win_count = r_cnt + CNT_W'(i_spike & ~w_at_max);
  assign win_sat   = r_sat | (i_spike & w_at_max);

  // While not running the window length tracks the input, so the value
  // present on the enabling edge is the one captured for the first window.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt       <= '0;
      r_wcnt      <= '0;
      r_sat       <= 1'b0;
      r_win_len_q <= '0;
    end else if (!i_run || win_done) begin
      r_cnt       <= '0;
      r_wcnt      <= '0;
      r_sat       <= 1'b0;
      r_win_len_q <= i_win_len;
    end else begin
      r_cnt       <= win_count;
      r_wcnt      <= r_wcnt + WIN_W'(1);
      r_sat       <= win_sat;
    end
  end
endmodule

// File: rtl/spike_rate_decoder.sv
// Windowed spike-rate decoder: IDLE/COUNT FSM, single-entry result register
// with valid/ready handshake and sticky overrun.
module spike_rate_decoder
  import neuro_pkg::*;
#(
  parameter int CNT_W = NEURO_DATA_W,
  parameter int WIN_W = NEURO_WIN_W
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         spike,
  input  logic                         en,
  input  logic [WIN_W-1:0]             win_len,
  spike_rate_decoder_if.master         rd
);
  dec_state_t       r_state;
  logic [CNT_W-1:0] r_rate;
  logic             r_sat;
  logic             r_valid;
  logic             r_ovr;

  logic             w_run;
  logic             w_done;
  logic [CNT_W-1:0] w_count;
  logic             w_sat;

  // Dropping en stops counting on that same edge, so no close can fire.
  assign w_run = (r_state == COUNT) & en;

  spike_win_counter #(.CNT_W(CNT_W), .WIN_W(WIN_W)) u_win (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_run     (w_run),
    .i_spike   (spike),
    .i_win_len (win_len),
    .win_done  (w_done),
    .win_count (w_count),
    .win_sat   (w_sat)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_rate  <= '0;
      r_sat   <= 1'b0;
      r_valid <= 1'b0;
      r_ovr   <= 1'b0;
    end else begin
      case (r_state)
        IDLE:    if (en) r_state <= COUNT;
        COUNT:   if (!en) begin
                   r_state <= IDLE;
                   r_ovr   <= 1'b0;
                 end
        default: r_state <= IDLE;
      endcase

      if (w_done) begin
        r_rate  <= w_count;
        r_sat   <= w_sat;
        r_valid <= 1'b1;
        if (r_valid && !rd.rate_ready) r_ovr <= 1'b1;
      end else if (r_valid && rd.rate_ready) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign rd.rate       = r_rate;
  assign rd.sat        = r_sat;
  assign rd.rate_valid = r_valid;
  assign rd.overrun    = r_ovr;
endmodule
